// File: rtl/mdp_ram_arb.sv
// ----------------------------------------------------------------------------
// mdp_ram_arb
//
// This block lets two requesters share one single-port MD+ command/status RAM.
// Port A is the MCU-side CPU-simulation path. Port B is the PI/SPI path from
// the everdrive MCU. Only one access is issued every two cycles. A two-state
// FSM (IDLE -> GRANT -> IDLE) sequences the accesses, and round-robin breaks
// ties between the ports.
//
// Timing, for a request sampled in IDLE at cycle N:
//   N+1 : ram_* strobes and x_ack are driven (GRANT).
//   N+2 : ram_rdata is valid (the RAM has one cycle of read latency).
//   N+3 : x_rvalid pulses and x_rdata is updated.
//
// The block also keeps a doorbell flag, cmd_pend.
//   - It is set when A writes DOORBELL_ADDR with the low byte enabled.
//   - It is cleared when B writes DOORBELL_ADDR with any byte enabled.
//   - The flag changes one cycle after the GRANT of that write.
//
// Ports
//   clk, rst_n                 system clock, asynchronous active-low reset
//   a_req/a_we/a_be/a_addr/a_wdata   port A request. Hold it stable until a_ack.
//   a_ack                      one-cycle pulse when the A access is issued
//   a_rvalid/a_rdata           A read return. a_rdata holds until the next A read.
//   b_*                        the same signals for port B
//   ram_ce/ram_we/ram_be/ram_addr/ram_wdata   RAM strobes, one cycle per grant
//   ram_rdata                  RAM read data, valid the cycle after ram_ce
//   cmd_pend                   doorbell flag: a command is pending for B
// ----------------------------------------------------------------------------
module mdp_ram_arb #(
  parameter int              AW            = 8,
  parameter int              DW            = 16,
  parameter logic [AW-1:0]   DOORBELL_ADDR = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [DW/8-1:0]   a_be,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_wdata,
  output logic              a_ack,
  output logic              a_rvalid,
  output logic [DW-1:0]     a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [DW/8-1:0]   b_be,
  input  logic [AW-1:0]     b_addr,
  input  logic [DW-1:0]     b_wdata,
  output logic              b_ack,
  output logic              b_rvalid,
  output logic [DW-1:0]     b_rdata,

  output logic              ram_ce,
  output logic              ram_we,
  output logic [DW/8-1:0]   ram_be,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata,

  output logic              cmd_pend
);

  localparam int BW = DW / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;

  // last_b_q = 1 means B won the most recent grant. It resets to B,
  // so A wins the first tie.
  logic              last_b_q, last_b_d;

  // This bit marks a GRANT cycle that carries a read. It arms the return path.
  logic              rd_issue_q, rd_issue_d;

  // The read return is tracked by one pending bit and one owner bit.
  // Reads are granted at most every 2 cycles, and the return takes 2 cycles,
  // so a second tracking slot is never needed.
  logic              rd_pend_q;
  logic              rd_owner_b_q;

  logic              ram_ce_d, ram_we_d;
  logic [BW-1:0]     ram_be_d;
  logic [AW-1:0]     ram_addr_d;
  logic [DW-1:0]     ram_wdata_d;
  logic              a_ack_d, b_ack_d;

  logic              win_b;
  logic              sel_we;
  logic [BW-1:0]     sel_be;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;

  logic              db_hit, db_set, db_clr;

  // Arbitration and request mux.
  // B wins when it is the only requester, or when both ports request
  // and A won the last grant.
  assign win_b     = b_req & (~a_req | ~last_b_q);
  assign sel_we    = win_b ? b_we    : a_we;
  assign sel_be    = win_b ? b_be    : a_be;
  assign sel_addr  = win_b ? b_addr  : a_addr;
  assign sel_wdata = win_b ? b_wdata : a_wdata;

  // Next-state and next-output logic for the FSM.
  // NOTE: every signal gets a default before the case statement. Without
  // the defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    rd_issue_d  = 1'b0;
    ram_ce_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_be_d    = '0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req | b_req) begin
          state_d     = GRANT;
          last_b_d    = win_b;
          rd_issue_d  = ~sel_we;
          ram_ce_d    = 1'b1;
          // A write with no byte enabled still gets an ack,
          // but it must leave the RAM untouched.
          ram_we_d    = sel_we & (|sel_be);
          ram_be_d    = sel_we ? sel_be : {BW{1'b1}};
          ram_addr_d  = sel_addr;
          ram_wdata_d = sel_we ? sel_wdata : '0;
          a_ack_d     = ~win_b;
          b_ack_d     = win_b;
        end
      end
      GRANT: begin
        // Requests are not sampled here. The strobes registered in IDLE
        // are live for this one cycle only.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registers for the FSM and the RAM strobes.
  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together at the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      rd_issue_q <= 1'b0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_be     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      rd_issue_q <= rd_issue_d;
      ram_ce     <= ram_ce_d;
      ram_we     <= ram_we_d;
      ram_be     <= ram_be_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      a_ack      <= a_ack_d;
      b_ack      <= b_ack_d;
    end
  end

  // Doorbell decode, evaluated in the GRANT cycle.
  // ram_we is only set for writes with a nonzero byte enable, so db_hit
  // already excludes reads and empty writes.
  assign db_hit = ram_ce & ram_we & (ram_addr == DOORBELL_ADDR);
  assign db_set = db_hit & a_ack & ram_be[0];
  assign db_clr = db_hit & b_ack;

  // Read return path and the doorbell flag.
  // Reset drops rd_pend_q, so a read in flight during reset is discarded
  // and never returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q    <= 1'b0;
      rd_owner_b_q <= 1'b0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      cmd_pend     <= 1'b0;
    end else begin
      rd_pend_q <= rd_issue_q;
      if (rd_issue_q) begin
        rd_owner_b_q <= b_ack;
      end

      a_rvalid <= rd_pend_q & ~rd_owner_b_q;
      b_rvalid <= rd_pend_q &  rd_owner_b_q;
      if (rd_pend_q & ~rd_owner_b_q) begin
        a_rdata <= ram_rdata;
      end
      if (rd_pend_q & rd_owner_b_q) begin
        b_rdata <= ram_rdata;
      end

      // Only one port is granted per cycle, so a set and a clear
      // can never coincide.
      if (db_set) begin
        cmd_pend <= 1'b1;
      end else if (db_clr) begin
        cmd_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mdp_ram_arb.sv
// ----------------------------------------------------------------------------
// tb_mdp_ram_arb
//
// Bench for mdp_ram_arb. It uses directed stimulus and a scoreboard.
// The issue task pushes two kinds of expected response:
//   - the expected grant: port, cycle and RAM strobe values;
//   - for reads, the expected return: data and cycle.
// A negedge monitor pops and compares each one at its due cycle.
// A small behavioural RAM with one-cycle read latency stands in for the
// real memory.
// ----------------------------------------------------------------------------
module tb_mdp_ram_arb;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [1:0]  a_be, b_be;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, a_rvalid, b_ack, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        ram_ce, ram_we;
  logic [1:0]  ram_be;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic        cmd_pend;

  mdp_ram_arb #(.AW(8), .DW(16), .DOORBELL_ADDR(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cmd_pend(cmd_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM. Read data appears the cycle after ram_ce.
  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    ram_rdata = 16'h0000;
  end
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we && ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      if (ram_we && ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
      ram_rdata <= mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        port;   // 0 = A, 1 = B
    logic        we;
    logic [1:0]  be;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic        chk_wd;
  } ack_t;

  typedef struct {
    int          cyc;
    logic [15:0] d;
  } rd_t;

  ack_t ack_q[$];
  rd_t  a_q[$];
  rd_t  b_q[$];
  logic [15:0] exp_a_last = 16'h0000;
  logic [15:0] exp_b_last = 16'h0000;

  // Monitor: on every cycle outside reset, each output is compared with the
  // scoreboard entry due in that cycle, or with zero if no entry is due.
  ack_t ae;
  rd_t  re;
  logic exp_ack, exp_av, exp_bv;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_ack = (ack_q.size() > 0) && (ack_q[0].cyc == cyc);
      check("ram_ce", {31'd0, ram_ce}, {31'd0, exp_ack});
      if (exp_ack) begin
        ae = ack_q.pop_front();
        check("a_ack", {31'd0, a_ack}, {31'd0, !ae.port});
        check("b_ack", {31'd0, b_ack}, {31'd0, ae.port});
        check("ram_we", {31'd0, ram_we}, {31'd0, ae.we});
        check("ram_be", {30'd0, ram_be}, {30'd0, ae.be});
        check("ram_addr", {24'd0, ram_addr}, {24'd0, ae.addr});
        if (ae.chk_wd) check("ram_wdata", {16'd0, ram_wdata}, {16'd0, ae.wd});
      end else begin
        check("no_ack", {30'd0, a_ack, b_ack}, 32'd0);
      end

      exp_av = (a_q.size() > 0) && (a_q[0].cyc == cyc);
      check("a_rvalid", {31'd0, a_rvalid}, {31'd0, exp_av});
      if (exp_av) begin
        re = a_q.pop_front();
        exp_a_last = re.d;
        check("a_rdata", {16'd0, a_rdata}, {16'd0, re.d});
        check("b_rdata_held", {16'd0, b_rdata}, {16'd0, exp_b_last});
      end

      exp_bv = (b_q.size() > 0) && (b_q[0].cyc == cyc);
      check("b_rvalid", {31'd0, b_rvalid}, {31'd0, exp_bv});
      if (exp_bv) begin
        re = b_q.pop_front();
        exp_b_last = re.d;
        check("b_rdata", {16'd0, b_rdata}, {16'd0, re.d});
        check("a_rdata_held", {16'd0, a_rdata}, {16'd0, exp_a_last});
      end
    end
  end

  // Issue one access from an IDLE cycle N (called at its negedge).
  // The task returns at the negedge of the ack cycle N+1, with req dropped.
  task automatic issue(input logic port, input logic we, input logic [1:0] be,
                       input logic [7:0] addr, input logic [15:0] wd,
                       input logic [15:0] rd_exp);
    ack_t e;
    rd_t  r;
    e.cyc    = cyc + 1;
    e.port   = port;
    e.we     = we && (be != 2'b00);
    e.be     = we ? be : 2'b11;
    e.addr   = addr;
    e.wd     = wd;
    e.chk_wd = we && (be != 2'b00);
    ack_q.push_back(e);
    if (!we) begin
      r.cyc = cyc + 3;
      r.d   = rd_exp;
      if (port) b_q.push_back(r); else a_q.push_back(r);
    end
    if (port) begin
      b_we = we; b_be = be; b_addr = addr; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_we = we; a_be = be; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    end
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ram_ce"},    {31'd0, ram_ce}, 32'd0);
    check({tag, "_ram_we"},    {31'd0, ram_we}, 32'd0);
    check({tag, "_ram_be"},    {30'd0, ram_be}, 32'd0);
    check({tag, "_ram_addr"},  {24'd0, ram_addr}, 32'd0);
    check({tag, "_ram_wdata"}, {16'd0, ram_wdata}, 32'd0);
    check({tag, "_acks"},      {30'd0, a_ack, b_ack}, 32'd0);
    check({tag, "_rvalids"},   {30'd0, a_rvalid, b_rvalid}, 32'd0);
    check({tag, "_a_rdata"},   {16'd0, a_rdata}, 32'd0);
    check({tag, "_b_rdata"},   {16'd0, b_rdata}, 32'd0);
    check({tag, "_cmd_pend"},  {31'd0, cmd_pend}, 32'd0);
  endtask

  ack_t ce;
  int   n0;

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_be = 2'b00; a_addr = 8'h00; a_wdata = 16'h0000;
    b_req = 1'b0; b_we = 1'b0; b_be = 2'b00; b_addr = 8'h00; b_wdata = 16'h0000;
    #1;
    check_zero("rst_imm");
    repeat (3) step();
    check_zero("rst");

    // Contention from reset: both requests are held through reset release.
    // A wins the first tie, then the grants alternate, one every 2 cycles.
    n0 = cyc;
    for (int k = 0; k < 8; k++) begin
      ce.cyc = n0 + 1 + 2 * k; ce.port = k[0]; ce.we = 1'b1; ce.be = 2'b11;
      ce.addr = k[0] ? 8'h31 : 8'h30; ce.wd = k[0] ? 16'h5555 : 16'hAAAA; ce.chk_wd = 1'b1;
      ack_q.push_back(ce);
    end
    a_we = 1'b1; a_be = 2'b11; a_addr = 8'h30; a_wdata = 16'hAAAA; a_req = 1'b1;
    b_we = 1'b1; b_be = 2'b11; b_addr = 8'h31; b_wdata = 16'h5555; b_req = 1'b1;
    rst_n = 1'b1;
    repeat (15) step();
    a_req = 1'b0; b_req = 1'b0;
    step();

    // A write of 8'h10, then a read of it back.
    issue(1'b0, 1'b1, 2'b11, 8'h10, 16'hBEEF, 16'h0000); step();
    issue(1'b0, 1'b0, 2'b00, 8'h10, 16'h0000, 16'hBEEF); step();

    // Byte-enable masking, including a write with no byte enabled.
    issue(1'b0, 1'b1, 2'b11, 8'h20, 16'h1234, 16'h0000); step();
    issue(1'b1, 1'b1, 2'b01, 8'h20, 16'hFFAA, 16'h0000); step();
    issue(1'b0, 1'b0, 2'b00, 8'h20, 16'h0000, 16'h12AA); step();
    issue(1'b0, 1'b1, 2'b00, 8'h20, 16'h9999, 16'h0000); step();
    issue(1'b0, 1'b0, 2'b00, 8'h20, 16'h0000, 16'h12AA); step();

    // Doorbell sequence.
    issue(1'b0, 1'b1, 2'b01, 8'hFF, 16'h0001, 16'h0000);
    check("db_set_n1", {31'd0, cmd_pend}, 32'd0);
    step();
    check("db_set_n2", {31'd0, cmd_pend}, 32'd1);
    issue(1'b0, 1'b1, 2'b10, 8'hFF, 16'h0200, 16'h0000); step();
    check("db_a_be10", {31'd0, cmd_pend}, 32'd1);
    issue(1'b1, 1'b0, 2'b00, 8'hFF, 16'h0000, 16'h0201); step();
    check("db_b_read", {31'd0, cmd_pend}, 32'd1);
    issue(1'b1, 1'b1, 2'b11, 8'hFF, 16'h0000, 16'h0000);
    check("db_clr_n1", {31'd0, cmd_pend}, 32'd1);
    step();
    check("db_clr_n2", {31'd0, cmd_pend}, 32'd0);

    // Read data routing: an A read and a B read, interleaved.
    issue(1'b0, 1'b1, 2'b11, 8'h01, 16'h0101, 16'h0000); step();
    issue(1'b1, 1'b1, 2'b11, 8'h02, 16'h0202, 16'h0000); step();
    issue(1'b0, 1'b0, 2'b00, 8'h01, 16'h0000, 16'h0101); step();
    issue(1'b1, 1'b0, 2'b00, 8'h02, 16'h0000, 16'h0202); step();
    repeat (4) step();

    // Reset asserted in cycle N+2 of an A read, with cmd_pend set.
    issue(1'b0, 1'b1, 2'b01, 8'hFF, 16'h0001, 16'h0000); step();
    check("db_preset", {31'd0, cmd_pend}, 32'd1);
    issue(1'b0, 1'b0, 2'b00, 8'h10, 16'h0000, 16'hBEEF);
    step();
    rst_n = 1'b0;
    a_q.delete();
    exp_a_last = 16'h0000;
    exp_b_last = 16'h0000;
    #1;
    check_zero("midrd");
    repeat (2) step();
    check_zero("midrd_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_stale_rvalid", {31'd0, a_rvalid}, 32'd0);
    end
    issue(1'b0, 1'b0, 2'b00, 8'h20, 16'h0000, 16'h12AA); step();
    repeat (4) step();
    check("post_rst_cmd_pend", {31'd0, cmd_pend}, 32'd0);

    check("ack_q_drained", ack_q.size(), 32'd0);
    check("a_q_drained", a_q.size(), 32'd0);
    check("b_q_drained", b_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdp_ram_arb.md
# mdp_ram_arb

Two-port round-robin arbiter that shares one single-port 256x16 MD+ command/status RAM between two requesters. Port A is the MCU-side CPU-simulation path; port B is the PI/SPI path from the everdrive MCU. The block sequences each access onto the RAM and returns read data with a fixed latency. It also maintains a doorbell flag: A sets it when posting a command, and B clears it when acknowledging the command.

## Interface
Parameters:
- AW, 8, RAM address width.
- DW, 16, data width; byte enables cover DW/8 bytes.
- DOORBELL_ADDR, 8'hFF, word address whose write sets or clears cmd_pend.

Ports:
- clk  in  1  system clock (mcu.clk domain).
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; a_we, a_be, a_addr and a_wdata must be held stable until a_ack.
- a_we  in  1  1 = write, 0 = read.
- a_be  in  2  byte enables; [0] = bits 7:0, [1] = bits 15:8.
- a_addr  in  AW  word address.
- a_wdata  in  DW  write data.
- a_ack  out  1  one-cycle pulse: the access has been issued.
- a_rvalid  out  1  one-cycle pulse: a_rdata is valid.
- a_rdata  out  DW  read data; holds its value until the next A read returns.
- b_req, b_we, b_be, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: same as the A port, for port B.
- ram_ce  out  1  RAM access strobe.
- ram_we  out  1  RAM write.
- ram_be  out  2  RAM byte enables.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid in the cycle after ram_ce.
- cmd_pend  out  1  doorbell flag: a command is pending for B.

## Operation
- FSM has two states, IDLE and GRANT. Reset state is IDLE.
- IDLE: if any request is active, choose a winner, register the RAM outputs and the ack for that port, then move to GRANT. Otherwise stay in IDLE with ram_ce=0.
- GRANT: ram_* outputs and the winner's ack are active for exactly this cycle. Requests are not sampled. Always return to IDLE.
- Consequence: at most one access every 2 cycles. A requester drops req, or presents a new request, in the cycle after it sees ack.
- Round-robin rule: when only one request is active, that port wins. When both are active, the port not granted last wins. The last-grant pointer resets to B, so A wins the first tie.
- Writes: ram_we=1 and ram_be=x_be. A write with be=2'b00 still acks, but drives ram_we=0 and ram_be=0. RAM contents are not changed.
- Reads: ram_we=0, ram_be=2'b11. One read-pending bit and one owner bit are tracked. ram_rdata is captured into the owner's rdata register, and the owner's rvalid pulses.
- Doorbell:
  - A write granted to DOORBELL_ADDR with be[0]=1 sets cmd_pend.
  - A B write granted to DOORBELL_ADDR with any nonzero be clears cmd_pend.
  - A and B reads of DOORBELL_ADDR do not affect cmd_pend.
  - Doorbell writes are still performed on the RAM.
- Since only one grant is issued per cycle, a set and a clear can never coincide. Set-while-set and clear-while-clear are no-ops.

## Timing
- Request sampled in IDLE at cycle N.
  - N+1: ram_ce=1 and x_ack=1.
  - N+2: ram_rdata valid.
  - N+3: x_rvalid=1 and x_rdata updated.
- Read latency from request to rvalid is 3 cycles.
- cmd_pend changes in cycle N+2, the cycle after the doorbell write's GRANT cycle.
- Back-to-back case: A is held continuously and B is held continuously. Grants alternate A, B, A, B, ..., one grant every 2 cycles.
- Read returns from consecutive grants never overlap. At most one is pending at a time, because the spacing is 2 cycles and the return path is 2 cycles.
- While rst_n=0, and immediately on its assertion, all of the following hold:
  - FSM is in IDLE.
  - ram_ce, ram_we, ram_be, ram_addr and ram_wdata are 0.
  - a_ack, b_ack, a_rvalid and b_rvalid are 0.
  - a_rdata and b_rdata are 0.
  - cmd_pend is 0.
  - The last-grant pointer is B.
- A read in flight when reset asserts is discarded. No rvalid is produced after reset releases.
- A request held through reset deassertion is sampled in the first IDLE cycle after release.

## Test plan
- Single A write then read: write addr 8'h10, be=11, data 16'hBEEF; then read 8'h10. Expect a_ack one cycle after each request is sampled, a_rvalid 3 cycles after the read request is sampled, and a_rdata=16'hBEEF.
- Byte-enable masking: write 8'h20=16'h1234, then B writes be=01 data 16'hFFAA. A read returns 16'h12AA. A write with be=00 returns ack, leaves ram_we low, and leaves the data unchanged.
- Contention: hold a_req and b_req for 8 grants starting from reset. Grant order is A,B,A,B,A,B,A,B. No cycle has both acks, and acks are spaced 2 cycles apart.
- Doorbell:
  - A writes 8'hFF with be=01: cmd_pend rises 2 cycles after that request is sampled.
  - A writes 8'hFF with be=10: no change.
  - B reads 8'hFF: cmd_pend stays 1.
  - B writes 8'hFF with be=11: cmd_pend falls.
- Read data routing: interleave an A read of 8'h01 (holding 16'h0101) with a B read of 8'h02 (holding 16'h0202). Each rvalid goes only to its owner, with the correct data, and the other port's rdata is unchanged.
- Reset mid-read: assert rst_n=0 in cycle N+2 of an A read. All outputs go to 0. After release, no a_rvalid appears within 5 cycles, and a new request completes normally.
